game_input_conditioner: RTL

GAME_INPUT_CONDITIONER -- requirements
Module: game_input_conditioner

---
 rtl/game_input_conditioner.sv | 84 ++++++++
 1 files changed

// File: rtl/game_input_conditioner.sv
// Input conditioning for the game controls: synchronises, debounces and arbitrates
// the slide switches, and turns the active-low buttons into clean levels plus press pulses.
module game_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CTR_W           = 20
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic raw_left_switch,
    input  logic raw_right_switch,
    input  logic raw_jump_button,
    input  logic raw_start_button,
    output logic left_switch,
    output logic right_switch,
    output logic jump_button,
    output logic start_button,
    output logic jump_press,
    output logic start_press,
    output logic lr_conflict
);

    // Channel order {start, jump, right, left}: buttons idle high, switches idle low.
    localparam logic [3:0]       RST_VAL = 4'b1100;
    localparam logic [CTR_W-1:0] CNT_TC  = CTR_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw_vec;
    logic [3:0]       sync_meta;
    logic [3:0]       sync_out;
    logic [3:0]       stable;
    logic [1:0]       btn_prev;
    logic [CTR_W-1:0] cnt [4];

    assign raw_vec = {raw_start_button, raw_jump_button, raw_right_switch, raw_left_switch};

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= RST_VAL;
            sync_out  <= RST_VAL;
        end else begin
            sync_meta <= raw_vec;
            sync_out  <= sync_meta;
        end
    end

    // The counter only runs while the synchronised input disagrees with the accepted
    // value, and the terminal count both accepts the new value and clears, so it never wraps.
    for (genvar ch = 0; ch < 4; ch++) begin : g_chan
        always_ff @(posedge vga_clock or negedge reset) begin
            if (!reset) begin
                stable[ch] <= RST_VAL[ch];
                cnt[ch]    <= '0;
            end else if (sync_out[ch] == stable[ch]) begin
                cnt[ch] <= '0;
            end else if (cnt[ch] == CNT_TC) begin
                stable[ch] <= sync_out[ch];
                cnt[ch]    <= '0;
            end else begin
                cnt[ch] <= cnt[ch] + CTR_W'(1);
            end
        end
    end

    assign jump_button  = stable[2];
    assign start_button = stable[3];

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            btn_prev     <= RST_VAL[3:2];
            jump_press   <= 1'b0;
            start_press  <= 1'b0;
            lr_conflict  <= 1'b0;
            left_switch  <= 1'b0;
            right_switch <= 1'b0;
        end else begin
            btn_prev     <= stable[3:2];
            jump_press   <= btn_prev[0] & ~stable[2];
            start_press  <= btn_prev[1] & ~stable[3];
            lr_conflict  <= stable[0] & stable[1];
            left_switch  <= stable[0] & ~stable[1];
            right_switch <= stable[1] & ~stable[0];
        end
    end

endmodule
